// File: rtl/key_search_pkg.sv
// Shared types and character-class helpers for the RC4 brute-force key sequencer.
package key_search_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RESTART,
        RUN,
        RD_ADDR,
        RD_WAIT,
        RD_CMP,
        NEXT,
        FOUND,
        EXHAUSTED
    } ks_state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

    // Plaintext alphabet is lowercase a-z plus space; everything else rejects the key.
    function automatic bit is_valid_char(logic [7:0] c);
        return (c == CHAR_SPACE) || ((c >= CHAR_LO) && (c <= CHAR_HI));
    endfunction

endpackage

// File: rtl/key_search_ctrl.sv
// RC4 key search sequencer: restarts the decrypt datapath per key and scans d_mem for plain text.
// Optional KEY_SEARCH_EARLY_ABORT_EN: abandon a key at its first invalid byte instead of scanning all bytes.
module key_search_ctrl
    import key_search_pkg::*;
#(
    parameter int          MSG_LEN = 32,
    parameter logic [23:0] KEY_MIN = 24'h000000,
    parameter logic [23:0] KEY_MAX = 24'h3FFFFF,
    parameter int          ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [23:0]       secret_key,
    output logic              dp_reset,
    output logic              dp_start,
    input  logic              dp_done,
    output logic [ADDR_W-1:0] d_rd_addr,
    input  logic [7:0]        d_rd_data,
    output logic              busy,
    output logic              found,
    output logic              exhausted
);

    localparam int              IDX_W    = $clog2(MSG_LEN) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    ks_state_t         state;
    logic [IDX_W-1:0]  idx;
    logic              bad;
    logic              cur_invalid;

    assign cur_invalid = !is_valid_char(d_rd_data);

    // Outputs are registered and take the value belonging to the state being entered,
    // so d_rd_addr changes on entry to RD_ADDR and the sample in RD_CMP is two cycles later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            secret_key <= KEY_MIN;
            dp_reset   <= 1'b0;
            dp_start   <= 1'b0;
            d_rd_addr  <= '0;
            busy       <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            idx        <= '0;
            bad        <= 1'b0;
        end else begin
            case (state)
                IDLE, FOUND, EXHAUSTED: begin
                    if (start) begin
                        secret_key <= KEY_MIN;
                        found      <= 1'b0;
                        exhausted  <= 1'b0;
                        busy       <= 1'b1;
                        dp_reset   <= 1'b1;
                        dp_start   <= 1'b0;
                        idx        <= '0;
                        bad        <= 1'b0;
                        state      <= RESTART;
                    end
                end
                RESTART: begin
                    dp_reset <= 1'b0;
                    dp_start <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (dp_done) begin
                        dp_start  <= 1'b0;
                        d_rd_addr <= ADDR_W'(idx);
                        state     <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    state <= RD_CMP;
                end
                RD_CMP: begin
`ifdef KEY_SEARCH_EARLY_ABORT_EN
                    if (cur_invalid) begin
                        state <= NEXT;
                    end else if (idx == LAST_IDX) begin
                        if (bad) begin
                            state <= NEXT;
                        end else begin
                            found <= 1'b1;
                            busy  <= 1'b0;
                            state <= FOUND;
                        end
                    end else begin
                        idx       <= idx + 1'b1;
                        d_rd_addr <= ADDR_W'(idx + 1'b1);
                        state     <= RD_ADDR;
                    end
`else
                    if (idx == LAST_IDX) begin
                        if (bad || cur_invalid) begin
                            state <= NEXT;
                        end else begin
                            found <= 1'b1;
                            busy  <= 1'b0;
                            state <= FOUND;
                        end
                    end else begin
                        bad       <= bad | cur_invalid;
                        idx       <= idx + 1'b1;
                        d_rd_addr <= ADDR_W'(idx + 1'b1);
                        state     <= RD_ADDR;
                    end
`endif
                end
                NEXT: begin
                    // The key space does not wrap: the last key is left on secret_key when exhausted.
                    if (secret_key == KEY_MAX) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state     <= EXHAUSTED;
                    end else begin
                        secret_key <= secret_key + 24'd1;
                        dp_reset   <= 1'b1;
                        idx        <= '0;
                        bad        <= 1'b0;
                        state      <= RESTART;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl: two instances (KEY_MAX 5 and 3) with a keyed d_mem and datapath model.
module tb_key_search_ctrl;
    import key_search_pkg::*;

    localparam int RUN_CYC = 11;
    localparam int TIMEOUT = 20000;

    logic        clk;
    logic        reset_n;

    logic        start_a, dpr_a, dps_a, done_a, busy_a, found_a, exh_a;
    logic [23:0] key_a;
    logic [7:0]  addr_a, data_a, q1_a;
    logic        start_b, dpr_b, dps_b, done_b, busy_b, found_b, exh_b;
    logic [23:0] key_b;
    logic [7:0]  addr_b, data_b, q1_b;

    int          good_a, good_b, bad_pos;
    logic [7:0]  b31;
    int          cnt_a, cnt_b;
    int          pulses_a, pulses_b;
    int          cyc, last_rst_a, gap_a;
    int          checks, errors;

    key_search_ctrl #(.MSG_LEN(32), .KEY_MIN(24'h000000), .KEY_MAX(24'h000005), .ADDR_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .secret_key(key_a), .dp_reset(dpr_a),
        .dp_start(dps_a), .dp_done(done_a), .d_rd_addr(addr_a), .d_rd_data(data_a),
        .busy(busy_a), .found(found_a), .exhausted(exh_a)
    );

    key_search_ctrl #(.MSG_LEN(32), .KEY_MIN(24'h000000), .KEY_MAX(24'h000003), .ADDR_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .secret_key(key_b), .dp_reset(dpr_b),
        .dp_start(dps_b), .dp_done(done_b), .d_rd_addr(addr_b), .d_rd_data(data_b),
        .busy(busy_b), .found(found_b), .exhausted(exh_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Text for the good key is all valid; other keys carry one 8'h7B at bad_pos.
    function automatic logic [7:0] mem_byte(int key, int good, int addr);
        if (key == good) begin
            if (addr == 31)
                return b31;
            else if (addr % 5 == 4)
                return 8'h20;
            else
                return 8'(8'h61 + addr % 26);
        end
        if (addr == bad_pos)
            return 8'h7B;
        return 8'(8'h61 + addr % 26);
    endfunction

    // Two-register read path and a datapath that finishes 10 cycles after dp_start rises.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q1_a <= 8'h00; data_a <= 8'h00; q1_b <= 8'h00; data_b <= 8'h00;
            cnt_a <= 0; done_a <= 1'b0; cnt_b <= 0; done_b <= 1'b0;
        end else begin
            q1_a   <= mem_byte(int'(key_a), good_a, int'(addr_a));
            data_a <= q1_a;
            q1_b   <= mem_byte(int'(key_b), good_b, int'(addr_b));
            data_b <= q1_b;
            if (dpr_a) begin
                cnt_a <= 0; done_a <= 1'b0;
            end else if (dps_a && !done_a) begin
                cnt_a <= cnt_a + 1;
                if (cnt_a == 9) done_a <= 1'b1;
            end
            if (dpr_b) begin
                cnt_b <= 0; done_b <= 1'b0;
            end else if (dps_b && !done_b) begin
                cnt_b <= cnt_b + 1;
                if (cnt_b == 9) done_b <= 1'b1;
            end
        end
    end

    initial begin
        cyc = 0; pulses_a = 0; pulses_b = 0; last_rst_a = 0; gap_a = 0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dpr_a) begin
            pulses_a   <= pulses_a + 1;
            gap_a      <= cyc - last_rst_a;
            last_rst_a <= cyc;
        end
        if (dpr_b) pulses_b <= pulses_b + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch a search on dut_a with start held high until it finishes, then drop start.
    task automatic applyStimulus(input int good, input logic [7:0] last_byte, input int bpos,
                                 output int pulse_delta);
        int p0;
        bit fin;
        good_a  = good;
        b31     = last_byte;
        bad_pos = bpos;
        p0      = pulses_a;
        start_a = 1'b1;
        @(negedge clk);
        fin = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (found_a || exh_a) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        checkOutput("run_a_finished", 32'(fin), 32'd1);
        pulse_delta = pulses_a - p0;
    endtask

    initial begin
        int          pd, p0, exp_gap;
        bit          fin;
        logic [7:0]  vals [6];
        bit          oks  [6];
        checks = 0; errors = 0;
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        good_a = 3; good_b = -1; bad_pos = 17; b31 = 8'h7A;
        repeat (3) @(negedge clk);

        checkOutput("rst_key", 32'(key_a), 32'h0);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_found", 32'(found_a), 32'd0);
        checkOutput("rst_exh", 32'(exh_a), 32'd0);
        checkOutput("rst_dp_reset", 32'(dpr_a), 32'd0);
        checkOutput("rst_dp_start", 32'(dps_a), 32'd0);
        checkOutput("rst_addr", 32'(addr_a), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] key 3 is the only valid key, KEY_MAX 5");
        applyStimulus(3, 8'h7A, 17, pd);
        checkOutput("t1_found", 32'(found_a), 32'd1);
        checkOutput("t1_key", 32'(key_a), 32'h3);
        checkOutput("t1_busy", 32'(busy_a), 32'd0);
        checkOutput("t1_exh", 32'(exh_a), 32'd0);
        checkOutput("t1_pulses", 32'(pd), 32'd4);
        p0 = pulses_a;
        repeat (5) @(negedge clk);
        checkOutput("t1_hold_found", 32'(found_a), 32'd1);
        checkOutput("t1_no_relaunch", 32'(pulses_a - p0), 32'd0);

        $display("[TB] no valid key, KEY_MAX 3");
        p0 = pulses_b;
        start_b = 1'b1;
        @(negedge clk);
        fin = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (found_b || exh_b) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start_b = 1'b0;
        checkOutput("t2_finished", 32'(fin), 32'd1);
        checkOutput("t2_exh", 32'(exh_b), 32'd1);
        checkOutput("t2_found", 32'(found_b), 32'd0);
        checkOutput("t2_key", 32'(key_b), 32'h3);
        checkOutput("t2_pulses", 32'(pulses_b - p0), 32'd4);

        $display("[TB] last byte boundary values");
        vals = '{8'h60, 8'h7B, 8'h40, 8'h20, 8'h61, 8'h7A};
        oks  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int v = 0; v < 6; v++) begin
            applyStimulus(3, vals[v], 17, pd);
            checkOutput($sformatf("t3_found_%02h", vals[v]), 32'(found_a), 32'(oks[v]));
            checkOutput($sformatf("t3_exh_%02h", vals[v]), 32'(exh_a), 32'(!oks[v]));
            checkOutput($sformatf("t3_key_%02h", vals[v]), 32'(key_a), oks[v] ? 32'h3 : 32'h5);
        end

        $display("[TB] first byte invalid: per-key cycle count");
`ifdef KEY_SEARCH_EARLY_ABORT_EN
        exp_gap = 1 + RUN_CYC + 3 * 1 + 1;
`else
        exp_gap = 1 + RUN_CYC + 3 * 32 + 1;
`endif
        applyStimulus(-1, 8'h7A, 0, pd);
        checkOutput("t5_exh", 32'(exh_a), 32'd1);
        checkOutput("t5_key", 32'(key_a), 32'h5);
        checkOutput("t5_gap", 32'(gap_a), 32'(exp_gap));
        applyStimulus(3, 8'h7A, 0, pd);
        checkOutput("t5_found_key", 32'(key_a), 32'h3);

        $display("[TB] reset during RD_WAIT of key 2");
        good_a = 3; b31 = 8'h7A; bad_pos = 17;
        start_a = 1'b1;
        fin = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (key_a == 24'h2 && dut_a.state == RD_WAIT) begin
                fin = 1'b1;
                break;
            end
        end
        checkOutput("t4_reached_rd_wait", 32'(fin), 32'd1);
        reset_n = 1'b0;
        start_a = 1'b0;
        #1;
        checkOutput("t4_key", 32'(key_a), 32'h0);
        checkOutput("t4_busy", 32'(busy_a), 32'd0);
        checkOutput("t4_dp_start", 32'(dps_a), 32'd0);
        checkOutput("t4_addr", 32'(addr_a), 32'd0);
        checkOutput("t4_found", 32'(found_a), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        checkOutput("t4_restart_pulse", 32'(dpr_a), 32'd1);
        checkOutput("t4_restart_key", 32'(key_a), 32'h0);
        checkOutput("t4_restart_busy", 32'(busy_a), 32'd1);

        $display("[TB] start held high through the search");
        fin = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (found_a || exh_a) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        checkOutput("t6_finished", 32'(fin), 32'd1);
        checkOutput("t6_key", 32'(key_a), 32'h3);
        checkOutput("t6_found", 32'(found_a), 32'd1);
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checkOutput("t6_relaunch_found", 32'(found_a), 32'd0);
        checkOutput("t6_relaunch_key", 32'(key_a), 32'h0);
        checkOutput("t6_relaunch_pulse", 32'(dpr_a), 32'd1);
        checkOutput("t6_relaunch_busy", 32'(busy_a), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
